// File: rtl/mult_pkg.sv
// Shared widths for the structural multiplier slice.
package mult_pkg;
    localparam int MULT_WIDTH  = 16;
    localparam int MULT_PWIDTH = 2 * MULT_WIDTH;
endpackage

// File: rtl/multiplier_if.sv
// Operand/product bundle for the multiplier; master drives operands, slave returns products.
interface multiplier_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2*WIDTH-1:0] PRODUCT;
    logic [2*WIDTH-1:0] PRODUCT_Q;
    logic               VALID_Q;

    modport master (output A, output B, input PRODUCT, input PRODUCT_Q, input VALID_Q);
    modport slave  (input A, input B, output PRODUCT, output PRODUCT_Q, output VALID_Q);
endinterface

// File: rtl/mult_full_adder.sv
// 1-bit full adder cell used by both the carry-save rows and the final ripple adder.
module mult_full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_cry
);
    assign o_sum = i_a ^ i_b ^ i_c;
    assign o_cry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// File: rtl/multiplier.sv
// Unsigned array multiplier: combinational PRODUCT (AND rows, carry-save rows, ripple adder),
// plus a 1-cycle registered copy PRODUCT_Q with VALID_Q; no backpressure.
module multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] PRODUCT,
    output logic [2*WIDTH-1:0] PRODUCT_Q,
    output logic               VALID_Q
);
    localparam int PW   = 2 * WIDTH;
    localparam int LAST = WIDTH - 1;

    logic [PW-1:0] w_product;
    logic [PW-1:0] r_product_q;
    logic          r_valid_q;

    genvar i, j;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_row
            logic [PW-1:0] w_pp;
            logic [PW-1:0] w_sum;
            logic [PW-1:0] w_cry;

            assign w_pp = {{WIDTH{1'b0}}, A & {WIDTH{B[i]}}} << i;

            if (i == 0) begin : g_init
                assign w_sum = w_pp;
                assign w_cry = '0;
            end else begin : g_csa
                assign w_cry[0] = 1'b0;
                for (j = 0; j < PW - 1; j++) begin : g_col
                    mult_full_adder u_fa (
                        .i_a   (g_row[i-1].w_sum[j]),
                        .i_b   (g_row[i-1].w_cry[j]),
                        .i_c   (w_pp[j]),
                        .o_sum (w_sum[j]),
                        .o_cry (w_cry[j+1])
                    );
                end
                // Carries out of the top column fall outside the 2*WIDTH result and are dropped.
                assign w_sum[PW-1] = g_row[i-1].w_sum[PW-1] ^ g_row[i-1].w_cry[PW-1] ^ w_pp[PW-1];
            end
        end

        for (j = 0; j < PW - 1; j++) begin : g_rc
            logic w_ci;
            logic w_co;
            if (j == 0) begin : g_first
                assign w_ci = 1'b0;
            end else begin : g_next
                assign w_ci = g_rc[j-1].w_co;
            end
            mult_full_adder u_fa (
                .i_a   (g_row[LAST].w_sum[j]),
                .i_b   (g_row[LAST].w_cry[j]),
                .i_c   (w_ci),
                .o_sum (w_product[j]),
                .o_cry (w_co)
            );
        end
    endgenerate

    // An in-range product never carries out of the MSB, so the top bit only needs the sum.
    assign w_product[PW-1] = g_row[LAST].w_sum[PW-1] ^ g_row[LAST].w_cry[PW-1] ^ g_rc[PW-2].w_co;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_product_q <= '0;
            r_valid_q   <= 1'b0;
        end else begin
            r_product_q <= w_product;
            r_valid_q   <= 1'b1;
        end
    end

    assign PRODUCT   = w_product;
    assign PRODUCT_Q = r_product_q;
    assign VALID_Q   = r_valid_q;
endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: vector table, registered/reset sequences, random vs. arithmetic model.
module tb_multiplier;
    import mult_pkg::*;

    localparam int W  = MULT_WIDTH;
    localparam int PW = MULT_PWIDTH;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    multiplier_if #(.WIDTH(W)) mif ();

    multiplier #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (mif.A),
        .B         (mif.B),
        .PRODUCT   (mif.PRODUCT),
        .PRODUCT_Q (mif.PRODUCT_Q),
        .VALID_Q   (mif.VALID_Q)
    );

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] p;
    } vec_t;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] wa;
        logic [63:0] wb;
        wa = 64'(a);
        wb = 64'(b);
        return wa * wb;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [12];
        logic [63:0] exp_p;
        logic [PW-1:0] held;

        checks = 0;
        errors = 0;
        RST    = 1'b1;
        mif.A  = '0;
        mif.B  = '0;

        vecs[0]  = '{16'd0,     16'd0,     32'd0};
        vecs[1]  = '{16'd15,    16'd3,     32'd45};
        vecs[2]  = '{16'd25,    16'd10,    32'd250};
        vecs[3]  = '{16'd255,   16'd2,     32'd510};
        vecs[4]  = '{16'd128,   16'd128,   32'd16384};
        vecs[5]  = '{16'd200,   16'd50,    32'd10000};
        vecs[6]  = '{16'd40000, 16'd2,     32'd80000};
        vecs[7]  = '{16'd65535, 16'd65535, 32'd4294836225};
        vecs[8]  = '{16'd65535, 16'd1,     32'd65535};
        vecs[9]  = '{16'd32768, 16'd2,     32'd65536};
        vecs[10] = '{16'd0,     16'd12345, 32'd0};
        vecs[11] = '{16'd54321, 16'd1,     32'd54321};

        #1;
        check("reset_product_q", 64'(mif.PRODUCT_Q), 64'd0);
        check("reset_valid_q",   64'(mif.VALID_Q),   64'd0);

        // Combinational table, held in reset so only PRODUCT can move.
        for (int k = 0; k < 12; k++) begin
            mif.A = vecs[k].a;
            mif.B = vecs[k].b;
            #1;
            check($sformatf("table_%0d_%0dx%0d", k, vecs[k].a, vecs[k].b),
                  64'(mif.PRODUCT), 64'(vecs[k].p));
        end
        check("table_product_q_still_reset", 64'(mif.PRODUCT_Q), 64'd0);
        check("table_valid_q_still_reset",   64'(mif.VALID_Q),   64'd0);

        // First edge after reset release loads the product and raises VALID_Q.
        @(negedge CLK);
        RST   = 1'b0;
        mif.A = 16'd300;
        mif.B = 16'd700;
        #1;
        check("pre_edge_product_q", 64'(mif.PRODUCT_Q), 64'd0);
        check("pre_edge_valid_q",   64'(mif.VALID_Q),   64'd0);
        @(posedge CLK);
        #1;
        check("first_edge_product_q", 64'(mif.PRODUCT_Q), 64'd210000);
        check("first_edge_valid_q",   64'(mif.VALID_Q),   64'd1);

        // Hold between edges.
        held  = mif.PRODUCT_Q;
        mif.A = 16'd1234;
        mif.B = 16'd5678;
        #1;
        check("hold_product_new",  64'(mif.PRODUCT),   64'd7006652);
        check("hold_product_q",    64'(mif.PRODUCT_Q), 64'd210000);
        @(posedge CLK);
        #1;
        check("hold_next_edge_q",  64'(mif.PRODUCT_Q), 64'd7006652);

        // Mid-run asynchronous reset.
        #2;
        mif.A = 16'd999;
        mif.B = 16'd111;
        check("midreset_q_nonzero_before", 64'(mif.PRODUCT_Q != '0), 64'd1);
        RST = 1'b1;
        #1;
        check("midreset_product_q", 64'(mif.PRODUCT_Q), 64'd0);
        check("midreset_valid_q",   64'(mif.VALID_Q),   64'd0);
        check("midreset_product",   64'(mif.PRODUCT),   64'd110889);
        @(posedge CLK);
        #1;
        check("midreset_held_q", 64'(mif.PRODUCT_Q), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Random pairs against the arithmetic model.
        for (int k = 0; k < 1000; k++) begin
            @(negedge CLK);
            mif.A = W'($urandom);
            mif.B = W'($urandom);
            if (k % 100 == 0) mif.A = '1;
            if (k % 100 == 1) mif.B = '1;
            exp_p = model(mif.A, mif.B);
            #1;
            check($sformatf("rand_%0d_product", k), 64'(mif.PRODUCT), exp_p);
            @(posedge CLK);
            #1;
            check($sformatf("rand_%0d_product_q", k), 64'(mif.PRODUCT_Q), exp_p);
            check($sformatf("rand_%0d_valid_q", k),   64'(mif.VALID_Q),   64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
